// File: rtl/memory_arbiter.sv
// Purpose : shares one single-ported unified memory between the instruction-fetch
//           port and the load/store data port, one transaction at a time.
// Latency : req (IDLE) -> mem_en +1 cycle -> ready +MEM_LATENCY+2 cycles; IDLE cycle between transactions.
// Backpr. : req/ready handshake; requests are only sampled in IDLE; stall holds the datapath meanwhile.
//
// Ports:
//   clk, reset                      rising-edge clock, synchronous active-high reset
//   i_req/i_addr -> i_rdata/i_ready instruction fetch port
//   d_req/d_we/d_addr/d_wdata ->    load/store port
//     d_rdata/d_ready
//   mem_en/mem_we/mem_addr/         registered memory strobe, write enable, address, write data
//     mem_wdata, mem_rdata          read data returns MEM_LATENCY cycles after the mem_en cycle
//   stall                           combinational: some request pending without its ready
//
// MEM_LATENCY is legal in 1..15 (the wait counter is 4 bits wide).
module memory_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t     state;
  logic [3:0] wait_cnt;
  logic       grant_data;       // 1 = data port owns the current transaction
  logic       last_grant_data;  // 1 = most recent grant went to the data port
  logic       pick_data;

  // Data wins when it is alone, or on a tie when fetch was not the previous loser
  // (i.e. the port not granted last is served).
  assign pick_data = d_req & (~i_req | ~last_grant_data);

  assign stall = (i_req & ~i_ready) | (d_req & ~d_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      wait_cnt        <= 4'd0;
      grant_data      <= 1'b0;
      last_grant_data <= 1'b1;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= 32'd0;
      mem_wdata       <= 32'd0;
      i_ready         <= 1'b0;
      d_ready         <= 1'b0;
      i_rdata         <= 32'd0;
      d_rdata         <= 32'd0;
    end else begin
      // Strobes are single-cycle; they are only raised by the transitions below.
      mem_en  <= 1'b0;
      i_ready <= 1'b0;
      d_ready <= 1'b0;

      case (state)
        S_IDLE: begin
          if (i_req | d_req) begin
            grant_data      <= pick_data;
            last_grant_data <= pick_data;
            mem_en          <= 1'b1;
            mem_addr        <= pick_data ? d_addr : i_addr;
            // A fetch never writes, so it drives a clean zero write word.
            mem_we          <= pick_data & d_we;
            mem_wdata       <= pick_data ? d_wdata : 32'd0;
            state           <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          // Reloaded on every issue, so the counter never needs to wrap.
          wait_cnt <= 4'(MEM_LATENCY - 1);
          state    <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_cnt == 4'd0) begin
            // mem_rdata is valid in this cycle; stores leave d_rdata untouched.
            if (!grant_data) begin
              i_rdata <= mem_rdata;
              i_ready <= 1'b1;
            end else begin
              if (!mem_we) begin
                d_rdata <= mem_rdata;
              end
              d_ready <= 1'b1;
            end
            state <= S_RESP;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        S_RESP: begin
          // The ready pulse is visible in this cycle; requests are re-arbitrated in IDLE.
          state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
